// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port instruction/data RAM between instruction fetch (IF)
// and the MEM pipeline stage. Only one RAM transaction is in flight at a time.
// The requester is stalled until its transaction completes. Load data is
// sign- or zero-extended according to the latched load kind and byte offset.
//
// Simultaneous requests are resolved in favour of MEM, because MEM holds the
// older instruction. A request seen in a DONE cycle is never accepted, so the
// instruction that is just completing cannot be issued a second time.
//
// Parameters
//   TIMEOUT_CYCLES  cycles ram_ce may stay high without ram_ack before the
//                   access is aborted. Legal range is 1..255 (8-bit counter).
//
// Optional feature (compile-time macro)
//   MEM_ARB_ALIGN_CHECK_EN  When defined, misaligned halfword/word MEM accesses
//                           never reach the RAM. They complete the next cycle
//                           with mem_err=1 and mem_rdata=0. When undefined, the
//                           low address bits only steer byte lanes, and mem_err
//                           reports timeouts only.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   if_req/if_addr   fetch request and word-aligned fetch address
//   if_inst/if_valid fetched word plus a 1-cycle valid pulse
//   mem_addr/sel/wdata/loadop
//                    MEM-stage request. A nonzero sel is a store. A loadop
//                    other than NOP is a load.
//   mem_rdata/done/err
//                    extended load data, 1-cycle done pulse, and error flag
//   stall_if/stall_mem
//                    combinational pipeline holds
//   ram_ce/we/addr/sel/wdata
//                    RAM request. ram_ce is held high until ram_ack.
//   ram_rdata/ram_ack
//                    RAM response. ram_rdata is sampled when ram_ack=1.
// -----------------------------------------------------------------------------

`ifndef MEM_LOADOP_BUS
`define MEM_LOADOP_BUS [2:0]
`endif
`ifndef MEM_LOADOP_NOP
`define MEM_LOADOP_NOP 3'd0
`endif
`ifndef MEM_LOADOP_LB
`define MEM_LOADOP_LB  3'd1
`endif
`ifndef MEM_LOADOP_LBU
`define MEM_LOADOP_LBU 3'd2
`endif
`ifndef MEM_LOADOP_LH
`define MEM_LOADOP_LH  3'd3
`endif
`ifndef MEM_LOADOP_LHU
`define MEM_LOADOP_LHU 3'd4
`endif
`ifndef MEM_LOADOP_LW
`define MEM_LOADOP_LW  3'd5
`endif

module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // instruction fetch side
  input  logic                   if_req,
  input  logic [31:0]            if_addr,
  output logic [31:0]            if_inst,
  output logic                   if_valid,
  // MEM stage side
  input  logic [31:0]            mem_addr,
  input  logic [3:0]             mem_sel,
  input  logic [31:0]            mem_wdata,
  input  logic `MEM_LOADOP_BUS   mem_loadop,
  output logic [31:0]            mem_rdata,
  output logic                   mem_done,
  output logic                   mem_err,
  // pipeline holds
  output logic                   stall_if,
  output logic                   stall_mem,
  // RAM port
  output logic                   ram_ce,
  output logic                   ram_we,
  output logic [31:0]            ram_addr,
  output logic [3:0]             ram_sel,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata,
  input  logic                   ram_ack
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_ACC,
    ST_MEM_ACC,
    ST_IF_DONE,
    ST_MEM_DONE
  } state_t;

  // The counter holds the number of ACC cycles that are already complete.
  // When it reaches TIMEOUT_CYCLES-1, the current cycle is the last one
  // allowed. This keeps ram_ce high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [7:0]             tmo_cnt;
  logic `MEM_LOADOP_BUS   lat_loadop;
  logic [1:0]             lat_off;

  logic                   mem_store;
  logic                   mem_req;
  logic                   mem_misaligned;
  logic                   acc_timeout;
  logic                   unused_if_low;

  assign mem_store   = |mem_sel;
  assign mem_req     = mem_store | (mem_loadop != `MEM_LOADOP_NOP);
  assign acc_timeout = (tmo_cnt == TIMEOUT_LAST);

  // Fetch addresses are word aligned, so the low bits carry no information.
  assign unused_if_low = ^if_addr[1:0];

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic half_acc;
  logic word_acc;
  assign half_acc = (mem_loadop == `MEM_LOADOP_LH) || (mem_loadop == `MEM_LOADOP_LHU) ||
                    (mem_sel == 4'b0011) || (mem_sel == 4'b1100);
  assign word_acc = (mem_loadop == `MEM_LOADOP_LW) || (mem_sel == 4'b1111);
  assign mem_misaligned = (half_acc && mem_addr[0]) ||
                          (word_acc && (mem_addr[1:0] != 2'b00));
`else
  assign mem_misaligned = 1'b0;
`endif

  // Stalls are combinational. The completing cycle releases the pipeline
  // in the same cycle as the done/valid pulse.
  assign stall_mem = mem_req & ~mem_done;
  assign stall_if  = (if_req & ~if_valid) | stall_mem;

  // Selects the addressed byte or halfword lane, then extends it to 32 bits.
  function automatic logic [31:0] extend_load(input logic `MEM_LOADOP_BUS op,
                                              input logic [1:0]           off,
                                              input logic [31:0]          word);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    case (off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (op)
      `MEM_LOADOP_LB:  extend_load = {{24{lane_b[7]}}, lane_b};
      `MEM_LOADOP_LBU: extend_load = {24'h0, lane_b};
      `MEM_LOADOP_LH:  extend_load = {{16{lane_h[15]}}, lane_h};
      `MEM_LOADOP_LHU: extend_load = {16'h0, lane_h};
      default:         extend_load = word;
    endcase
  endfunction

  // Single sequencing FSM. All RAM-side and requester-side outputs are
  // registered here.
  // NOTE: all state and outputs are cleared by the asynchronous reset, so an
  // access that is in flight ends immediately. ram_ce drops, no done pulse is
  // produced, and a late ack arrives in IDLE, where it is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      lat_loadop <= `MEM_LOADOP_NOP;
      lat_off    <= '0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_sel    <= '0;
      ram_wdata  <= '0;
      if_inst    <= '0;
      if_valid   <= 1'b0;
      mem_rdata  <= '0;
      mem_done   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make the done/valid flags 1-cycle pulses.
      // Any branch below may override them for the DONE cycle that follows.
      if_valid <= 1'b0;
      mem_done <= 1'b0;
      mem_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (mem_req && mem_misaligned) begin
            // The RAM is never touched. The error is reported on the next cycle.
            state     <= ST_MEM_DONE;
            mem_done  <= 1'b1;
            mem_err   <= 1'b1;
            mem_rdata <= '0;
          end else if (mem_req) begin
            state      <= ST_MEM_ACC;
            ram_ce     <= 1'b1;
            ram_we     <= mem_store;
            ram_addr   <= {mem_addr[31:2], 2'b00};
            ram_sel    <= mem_store ? mem_sel : 4'b1111;
            ram_wdata  <= mem_wdata;
            lat_loadop <= mem_loadop;
            lat_off    <= mem_addr[1:0];
          end else if (if_req) begin
            state    <= ST_IF_ACC;
            ram_ce   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= {if_addr[31:2], 2'b00};
            ram_sel  <= 4'b1111;
          end
        end

        ST_IF_ACC: begin
          if (ram_ack) begin
            ram_ce   <= 1'b0;
            if_valid <= 1'b1;
            if_inst  <= ram_rdata;
            state    <= ST_IF_DONE;
          end else if (acc_timeout) begin
            ram_ce   <= 1'b0;
            if_valid <= 1'b1;
            if_inst  <= '0;
            state    <= ST_IF_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        ST_MEM_ACC: begin
          if (ram_ack) begin
            ram_ce    <= 1'b0;
            mem_done  <= 1'b1;
            mem_rdata <= ram_we ? '0 : extend_load(lat_loadop, lat_off, ram_rdata);
            state     <= ST_MEM_DONE;
          end else if (acc_timeout) begin
            ram_ce    <= 1'b0;
            mem_done  <= 1'b1;
            mem_err   <= 1'b1;
            mem_rdata <= '0;
            state     <= ST_MEM_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        // Requests are deliberately ignored here. The completing requester
        // still presents the same request in this cycle.
        ST_IF_DONE,
        ST_MEM_DONE: state <= ST_IDLE;

        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule
